// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle between the 5-stage datapath and the hazard controller.
// The datapath (master) reports stage register indices, write enables and the
// mul/div handshake; the hazard unit (slave) returns stage stalls, flushes,
// operand-mux selects and the mul/div start pulse.
interface hazard_unit_mc_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rs1_e;
  logic [REG_ADDR_W-1:0] rs2_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic [REG_ADDR_W-1:0] rd_m;
  logic [REG_ADDR_W-1:0] rd_w;
  logic                  regwrite_e;
  logic                  regwrite_m;
  logic                  regwrite_w;
  logic [1:0]            resultsrc_e;
  logic                  pcsrc_e;
  logic                  md_op_e;
  logic                  md_done;
  logic                  md_start;
  logic                  stall_f;
  logic                  stall_d;
  logic                  stall_e;
  logic                  flush_d;
  logic                  flush_e;
  logic                  flush_m;
  logic [1:0]            forward_a;
  logic [1:0]            forward_b;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output regwrite_e, regwrite_m, regwrite_w, resultsrc_e, pcsrc_e,
    output md_op_e, md_done,
    input  md_start, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
    input  forward_a, forward_b
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  regwrite_e, regwrite_m, regwrite_w, resultsrc_e, pcsrc_e,
    input  md_op_e, md_done,
    output md_start, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
    output forward_a, forward_b
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32 pipeline: M/W forwarding, load-use stall,
// branch flush, multi-cycle mul/div hold and saturating perf counters.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no mul/div in flight; a mul/div in E starts the unit
//   MD_BUSY | mul/div running; F/D/E held and M bubbled until md_done
module hazard_unit_mc #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  parameter bit MD_EN      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_unit_mc_if.slave  hif,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] md_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t state_q, state_nxt;
  logic      md_hold;
  logic      md_go;
  logic      lu;

  // Operand source for E: a newer producer in M wins over an older one in W.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (hif.regwrite_m && hif.rd_m != REG_ZERO && hif.rd_m == rs)
      return 2'b10;
    else if (hif.regwrite_w && hif.rd_w != REG_ZERO && hif.rd_w == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Forwarding muxes are purely combinational and unaffected by reset.
  always_comb begin
    hif.forward_a = fwd_sel(hif.rs1_e);
    hif.forward_b = fwd_sel(hif.rs2_e);
  end

  // Load in E whose destination is read by the instruction in D.
  always_comb begin
    lu = (hif.resultsrc_e == 2'b01) && hif.regwrite_e && (hif.rd_e != REG_ZERO) &&
         (((hif.rs1_d != REG_ZERO) && (hif.rs1_d == hif.rd_e)) ||
          ((hif.rs2_d != REG_ZERO) && (hif.rs2_d == hif.rd_e)));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // FSM next state; hold starts in the launch cycle and drops in the done
  // cycle so E can capture the result. A taken branch blocks the launch.
  always_comb begin
    state_nxt = state_q;
    md_hold   = 1'b0;
    md_go     = 1'b0;
    case (state_q)
      IDLE: begin
        if (MD_EN && hif.md_op_e && !hif.pcsrc_e) begin
          state_nxt = MD_BUSY;
          md_hold   = 1'b1;
          md_go     = 1'b1;
        end
      end
      MD_BUSY: begin
        if (hif.md_done) state_nxt = IDLE;
        else             md_hold   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage controls, all forced low while reset is held.
  always_comb begin
    hif.md_start = rst_n & md_go;
    hif.stall_e  = rst_n & md_hold;
    hif.stall_d  = rst_n & (md_hold | lu);
    hif.stall_f  = rst_n & (md_hold | lu);
    hif.flush_m  = rst_n & md_hold;
    hif.flush_e  = rst_n & ((lu & ~md_hold) | hif.pcsrc_e);
    hif.flush_d  = rst_n & hif.pcsrc_e;
  end

  // Saturating performance counters; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_stall_cnt <= '0;
      md_stall_cnt   <= '0;
      flush_cnt      <= '0;
    end else if (perf_clr) begin
      load_stall_cnt <= '0;
      md_stall_cnt   <= '0;
      flush_cnt      <= '0;
    end else begin
      if (lu && !md_hold) load_stall_cnt <= sat_inc(load_stall_cnt);
      if (md_hold)        md_stall_cnt   <= sat_inc(md_stall_cnt);
      if (hif.pcsrc_e)    flush_cnt      <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: directed scenarios followed by random traffic,
// all compared against a behavioural model of the hazard rules.
module tb_hazard_unit_mc;
  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          perf_clr = 1'b0;
  logic [CW-1:0] lsc, msc, fc;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  bit m_busy = 1'b0;
  int m_lsc = 0, m_msc = 0, m_fc = 0;

  hazard_unit_mc_if #(.REG_ADDR_W(RW)) hif ();

  hazard_unit_mc #(.REG_ADDR_W(RW), .CNT_W(CW), .MD_EN(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hif            (hif.slave),
    .perf_clr       (perf_clr),
    .load_stall_cnt (lsc),
    .md_stall_cnt   (msc),
    .flush_cnt      (fc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fwd_exp(input int rs);
    if (hif.regwrite_m && hif.rd_m != 0 && int'(hif.rd_m) == rs) return 2;
    if (hif.regwrite_w && hif.rd_w != 0 && int'(hif.rd_w) == rs) return 1;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk_cnt();
    chk("load_stall_cnt", 32'(lsc), m_lsc);
    chk("md_stall_cnt", 32'(msc), m_msc);
    chk("flush_cnt", 32'(fc), m_fc);
  endtask

  // One pipeline cycle: inputs are already set; check mid-cycle, clock, check counters.
  task automatic cycle();
    bit lu, hold, start, r;
    #3;
    r = rst_n;
    if (!r) begin
      m_busy = 1'b0;
      m_lsc = 0; m_msc = 0; m_fc = 0;
    end
    if (r && hif.pcsrc_e && hif.md_op_e) begin
      failures++;
      $error("FAIL illegal_pcsrc_with_md_op observed=1 expected=0");
    end
    lu = (hif.resultsrc_e == 2'b01) && hif.regwrite_e && hif.rd_e != 0 &&
         ((hif.rs1_d != 0 && hif.rs1_d == hif.rd_e) || (hif.rs2_d != 0 && hif.rs2_d == hif.rd_e));
    start = r && !m_busy && hif.md_op_e && !hif.pcsrc_e;
    hold  = r && (m_busy ? !hif.md_done : start);
    chk("forward_a", 32'(hif.forward_a), fwd_exp(int'(hif.rs1_e)));
    chk("forward_b", 32'(hif.forward_b), fwd_exp(int'(hif.rs2_e)));
    chk("md_start", 32'(hif.md_start), 32'(start));
    chk("stall_f", 32'(hif.stall_f), 32'(r && (hold || lu)));
    chk("stall_d", 32'(hif.stall_d), 32'(r && (hold || lu)));
    chk("stall_e", 32'(hif.stall_e), 32'(hold));
    chk("flush_d", 32'(hif.flush_d), 32'(r && hif.pcsrc_e));
    chk("flush_e", 32'(hif.flush_e), 32'(r && ((lu && !hold) || hif.pcsrc_e)));
    chk("flush_m", 32'(hif.flush_m), 32'(hold));
    if (!r) chk_cnt();
    @(posedge clk);
    #1;
    if (r) begin
      m_busy = m_busy ? !hif.md_done : start;
      if (perf_clr) begin
        m_lsc = 0; m_msc = 0; m_fc = 0;
      end else begin
        if (lu && !hold) m_lsc = sat(m_lsc);
        if (hold)        m_msc = sat(m_msc);
        if (hif.pcsrc_e) m_fc  = sat(m_fc);
      end
    end
    chk_cnt();
  endtask

  task automatic idle_inputs();
    hif.rs1_d = '0; hif.rs2_d = '0; hif.rs1_e = '0; hif.rs2_e = '0;
    hif.rd_e = '0; hif.rd_m = '0; hif.rd_w = '0;
    hif.regwrite_e = 1'b0; hif.regwrite_m = 1'b0; hif.regwrite_w = 1'b0;
    hif.resultsrc_e = 2'b00; hif.pcsrc_e = 1'b0;
    hif.md_op_e = 1'b0; hif.md_done = 1'b0;
    perf_clr = 1'b0;
  endtask

  task automatic clear_cycle();
    idle_inputs();
    perf_clr = 1'b1;
    cycle();
    perf_clr = 1'b0;
  endtask

  task automatic set_load_use(input int rd, input int rs2);
    hif.resultsrc_e = 2'b01; hif.regwrite_e = 1'b1;
    hif.rd_e = RW'(rd); hif.rs2_d = RW'(rs2);
  endtask

  initial begin
    idle_inputs();
    // Reset state
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Forwarding priority
    hif.rd_m = 5'd5; hif.rd_w = 5'd5; hif.rs1_e = 5'd5;
    hif.regwrite_m = 1'b1; hif.regwrite_w = 1'b1;
    #3 chk("fwd_m_priority", 32'(hif.forward_a), 2);
    cycle();
    hif.regwrite_m = 1'b0;
    #3 chk("fwd_w_only", 32'(hif.forward_a), 1);
    cycle();
    hif.rs1_e = 5'd0;
    #3 chk("fwd_x0", 32'(hif.forward_a), 0);
    cycle();

    // Load-use: one bubble, then the load has moved on
    clear_cycle();
    set_load_use(7, 7);
    cycle();
    idle_inputs();
    cycle();
    chk("lu_single_count", 32'(lsc), 1);
    set_load_use(0, 0);
    cycle();
    idle_inputs();

    // Mul/div with done 4 cycles after start
    clear_cycle();
    hif.md_op_e = 1'b1;
    repeat (4) cycle();
    hif.md_done = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    chk("md_hold_cycles", 32'(msc), 4);

    // Branch flush, alone and with a coincident load-use
    clear_cycle();
    hif.pcsrc_e = 1'b1;
    cycle();
    set_load_use(9, 9);
    cycle();
    idle_inputs();
    cycle();
    chk("branch_flush_count", 32'(fc), 2);

    // Reset while MD_BUSY, then no restart without a new mul/div
    hif.md_op_e = 1'b1;
    cycle();
    cycle();
    rst_n = 1'b0;
    hif.md_op_e = 1'b0;
    #1 chk("rst_async_stall_e", 32'(hif.stall_e), 0);
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();

    // Saturation and clear-over-increment
    clear_cycle();
    set_load_use(3, 3);
    repeat (20) cycle();
    chk("lu_saturated", 32'(lsc), CMAX);
    perf_clr = 1'b1;
    cycle();
    perf_clr = 1'b0;
    chk("clr_beats_inc", 32'(lsc), 0);
    idle_inputs();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      hif.rs1_d = RW'($urandom_range(0, 7)); hif.rs2_d = RW'($urandom_range(0, 7));
      hif.rs1_e = RW'($urandom_range(0, 7)); hif.rs2_e = RW'($urandom_range(0, 7));
      hif.rd_e = RW'($urandom_range(0, 7)); hif.rd_m = RW'($urandom_range(0, 7));
      hif.rd_w = RW'($urandom_range(0, 7));
      hif.regwrite_e = 1'($urandom); hif.regwrite_m = 1'($urandom);
      hif.regwrite_w = 1'($urandom);
      hif.resultsrc_e = 2'($urandom);
      perf_clr = ($urandom_range(0, 99) < 3);
      if (m_busy) begin
        hif.md_op_e = 1'b1;
        hif.pcsrc_e = 1'b0;
        hif.md_done = ($urandom_range(0, 99) < 30);
      end else begin
        hif.md_op_e = ($urandom_range(0, 99) < 15);
        hif.pcsrc_e = hif.md_op_e ? 1'b0 : ($urandom_range(0, 99) < 12);
        hif.md_done = ($urandom_range(0, 99) < 5);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle_inputs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
